sort_chain: RTL and testbench



---
 rtl/sort_chain_pkg.sv | 21 ++
 rtl/sort_cell.sv | 85 ++++++++
 rtl/sort_chain.sv | 167 ++++++++++++++++
 tb/tb_sort_chain.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_chain_pkg.sv
// Shared types and defaults for the sort_chain insertion sorter.
// Optional tag storage is enabled by defining SORT_CHAIN_TAG_EN.
package sort_chain_pkg;

  localparam int DEFAULT_DATA_W = 10;
  localparam int DEFAULT_DEPTH  = 16;

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  typedef enum logic [2:0] {
    HOLD,
    LOAD_NEW,
    LOAD_ABOVE,
    LOAD_BELOW,
    EMPTY
  } cell_ctrl_t;

endpackage

// File: rtl/sort_cell.sv
// One stage of the sort chain: holds a valid bit, a value and (with SORT_CHAIN_TAG_EN) a tag.
// Reports whether the incoming sample beats the held value; an empty cell always loses.
module sort_cell
  import sort_chain_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
`ifdef SORT_CHAIN_TAG_EN
  ,
  parameter int TAG_W = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  cell_ctrl_t        ctrl,
  input  logic [DATA_W-1:0] new_data,
  input  logic              above_valid,
  input  logic [DATA_W-1:0] above_data,
  input  logic              below_valid,
  input  logic [DATA_W-1:0] below_data,
`ifdef SORT_CHAIN_TAG_EN
  input  logic [TAG_W-1:0]  new_tag,
  input  logic [TAG_W-1:0]  above_tag,
  input  logic [TAG_W-1:0]  below_tag,
  output logic [TAG_W-1:0]  tag,
`endif
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              gt
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;

  // Strict compare keeps equal values in arrival order.
  assign gt    = !valid_reg || (new_data > data_reg);
  assign valid = valid_reg;
  assign data  = data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      case (ctrl)
        LOAD_NEW: begin
          valid_reg <= 1'b1;
          data_reg  <= new_data;
        end
        LOAD_ABOVE: begin
          valid_reg <= above_valid;
          data_reg  <= above_data;
        end
        LOAD_BELOW: begin
          valid_reg <= below_valid;
          data_reg  <= below_data;
        end
        EMPTY: begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SORT_CHAIN_TAG_EN
  logic [TAG_W-1:0] tag_reg;
  assign tag = tag_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_reg <= '0;
    end else begin
      case (ctrl)
        LOAD_NEW:   tag_reg <= new_tag;
        LOAD_ABOVE: tag_reg <= above_tag;
        LOAD_BELOW: tag_reg <= below_tag;
        EMPTY:      tag_reg <= '0;
        default:    ;
      endcase
    end
  end
`endif

endmodule

// File: rtl/sort_chain.sv
// Systolic insertion sorter keeping the DEPTH largest samples of a burst, drained largest-first.
// Define SORT_CHAIN_TAG_EN to carry a per-sample tag alongside each value.
module sort_chain
  import sort_chain_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
`ifdef SORT_CHAIN_TAG_EN
  parameter int TAG_W  = 8,
`endif
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
`ifdef SORT_CHAIN_TAG_EN
  input  logic [TAG_W-1:0]  in_tag,
  output logic [TAG_W-1:0]  out_tag,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  count,
  output logic              busy
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [DEPTH-1:0]  gt;
  logic [DEPTH-1:0]  vld;
  logic [DATA_W-1:0] dat [DEPTH];
`ifdef SORT_CHAIN_TAG_EN
  logic [TAG_W-1:0]  tg  [DEPTH];
`endif

  logic accept;
  logic pop;

  assign in_ready  = (state_reg == FILL) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DRAIN) && (count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? dat[0] : '0;
  assign out_last  = out_valid && (count_reg == ONE);
  assign count     = count_reg;
  assign busy      = (state_reg == DRAIN);
`ifdef SORT_CHAIN_TAG_EN
  assign out_tag   = out_valid ? tg[0] : '0;
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (clear) begin
      state_next = FILL;
      count_next = '0;
    end else if (accept) begin
      if (in_last) state_next = DRAIN;
      // A full chain discards its tail, so occupancy saturates.
      if (count_reg != FULL) count_next = count_reg + ONE;
    end else if (pop) begin
      count_next = count_reg - ONE;
      if (count_reg == ONE) state_next = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FILL;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      cell_ctrl_t        ctrl;
      logic              gt_above;
      logic              above_valid, below_valid;
      logic [DATA_W-1:0] above_data, below_data;
`ifdef SORT_CHAIN_TAG_EN
      logic [TAG_W-1:0]  above_tag, below_tag;
`endif

      if (gi == 0) begin : g_top
        assign gt_above    = 1'b0;
        assign above_valid = 1'b0;
        assign above_data  = '0;
`ifdef SORT_CHAIN_TAG_EN
        assign above_tag   = '0;
`endif
      end else begin : g_mid_above
        assign gt_above    = gt[gi-1];
        assign above_valid = vld[gi-1];
        assign above_data  = dat[gi-1];
`ifdef SORT_CHAIN_TAG_EN
        assign above_tag   = tg[gi-1];
`endif
      end

      // The tail cell pulls in an empty slot while draining.
      if (gi == DEPTH - 1) begin : g_tail
        assign below_valid = 1'b0;
        assign below_data  = '0;
`ifdef SORT_CHAIN_TAG_EN
        assign below_tag   = '0;
`endif
      end else begin : g_mid_below
        assign below_valid = vld[gi+1];
        assign below_data  = dat[gi+1];
`ifdef SORT_CHAIN_TAG_EN
        assign below_tag   = tg[gi+1];
`endif
      end

      always_comb begin
        ctrl = HOLD;
        if (clear) begin
          ctrl = EMPTY;
        end else if (accept) begin
          if (gt_above)    ctrl = LOAD_ABOVE;
          else if (gt[gi]) ctrl = LOAD_NEW;
        end else if (pop) begin
          ctrl = LOAD_BELOW;
        end
      end

      sort_cell #(
        .DATA_W(DATA_W)
`ifdef SORT_CHAIN_TAG_EN
        ,
        .TAG_W(TAG_W)
`endif
      ) u_cell (
        .clk        (clk),
        .reset      (reset),
        .ctrl       (ctrl),
        .new_data   (in_data),
        .above_valid(above_valid),
        .above_data (above_data),
        .below_valid(below_valid),
        .below_data (below_data),
`ifdef SORT_CHAIN_TAG_EN
        .new_tag    (in_tag),
        .above_tag  (above_tag),
        .below_tag  (below_tag),
        .tag        (tg[gi]),
`endif
        .valid      (vld[gi]),
        .data       (dat[gi]),
        .gt         (gt[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sort_chain.sv
// Self-checking bench for sort_chain (DEPTH=4): literal vector table, hand-written
// corner sequences, and random bursts compared against a queue-based reference.
module tb_sort_chain;

  localparam int DW  = 10;
  localparam int DEP = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
`ifdef SORT_CHAIN_TAG_EN
  logic [7:0]    in_tag = '0;
  logic [7:0]    out_tag;
`endif

  sort_chain #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
`ifdef SORT_CHAIN_TAG_EN
    .in_tag   (in_tag),
    .out_tag  (out_tag),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .count    (count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d;
    int t;
  } item_t;
  item_t model[$];

  typedef struct {
    int len;
    int vals[8];
    int nexp;
    int exp[4];
  } vec_t;
  vec_t vecs[4];

  task automatic check(string name, int got, int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a descending list; a newcomer goes after every value >= itself.
  function automatic void model_insert(int v, int t);
    int pos = 0;
    item_t it;
    it.d = v;
    it.t = t;
    while (pos < model.size() && model[pos].d >= v) pos++;
    model.insert(pos, it);
    if (model.size() > DEP) void'(model.pop_back());
  endfunction

  task automatic push(int v, int t, bit last);
    in_valid = 1'b1;
    in_data  = DW'(v);
    in_last  = last;
`ifdef SORT_CHAIN_TAG_EN
    in_tag   = 8'(t);
`endif
    check("push_in_ready", int'(in_ready), 1);
    model_insert(v, t);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("fill_count", int'(count), model.size());
  endtask

  task automatic drain_model(bit rand_ready, bit noise);
    int guard = 0;
    while (model.size() > 0 && guard < 200) begin
      guard++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = DW'($urandom);
      check("drain_valid", int'(out_valid), 1);
      check("drain_data", int'(out_data), model[0].d);
      check("drain_last", int'(out_last), (model.size() == 1) ? 1 : 0);
      check("drain_count", int'(count), model.size());
`ifdef SORT_CHAIN_TAG_EN
      check("drain_tag", int'(out_tag), model[0].t);
`endif
      if (out_ready) void'(model.pop_front());
      step();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_remaining", model.size(), 0);
    check("post_drain_busy", int'(busy), 0);
    check("post_drain_count", int'(count), 0);
    check("post_drain_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{len: 4, vals: '{5, 9, 2, 7, 0, 0, 0, 0}, nexp: 4, exp: '{9, 7, 5, 2}};
    vecs[1] = '{len: 6, vals: '{3, 8, 1, 6, 4, 10, 0, 0}, nexp: 4, exp: '{10, 8, 6, 4}};
    vecs[2] = '{len: 2, vals: '{1, 1, 0, 0, 0, 0, 0, 0}, nexp: 2, exp: '{1, 1, 0, 0}};
    vecs[3] = '{len: 5, vals: '{0, 1023, 0, 1023, 512, 0, 0, 0}, nexp: 4, exp: '{1023, 1023, 512, 0}};

    // Reset state
    step();
    step();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
`ifdef SORT_CHAIN_TAG_EN
    check("rst_out_tag", int'(out_tag), 0);
`endif
    reset = 1'b0;
    #1;
    check("rst_release_in_ready", int'(in_ready), 1);

    // Table of bursts with literal expected drain order
    for (int v = 0; v < 4; v++) begin
      model.delete();
      for (int k = 0; k < vecs[v].len; k++)
        push(vecs[v].vals[k], k, k == vecs[v].len - 1);
      check("vec_busy", int'(busy), 1);
      check("vec_in_ready", int'(in_ready), 0);
      out_ready = 1'b1;
      for (int k = 0; k < vecs[v].nexp; k++) begin
        check("vec_valid", int'(out_valid), 1);
        check("vec_data", int'(out_data), vecs[v].exp[k]);
        check("vec_last", int'(out_last), (k == vecs[v].nexp - 1) ? 1 : 0);
        step();
      end
      out_ready = 1'b0;
      check("vec_end_valid", int'(out_valid), 0);
      check("vec_end_busy", int'(busy), 0);
      check("vec_end_count", int'(count), 0);
    end
    model.delete();

`ifdef SORT_CHAIN_TAG_EN
    // Ties keep arrival order of tags
    push(5, 1, 1'b0);
    push(5, 2, 1'b0);
    push(5, 3, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("tie_data", int'(out_data), 5);
      check("tie_tag", int'(out_tag), k + 1);
      step();
    end
    out_ready = 1'b0;
    check("tie_out_tag_idle", int'(out_tag), 0);
    model.delete();
`endif

    // Back-pressure with ignored input pulses
    begin
      bit rdy_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int dat_pat[5] = '{4, 3, 3, 3, 1};
      int cnt_pat[5] = '{3, 2, 2, 2, 1};
      push(4, 0, 1'b0);
      push(1, 0, 1'b0);
      push(3, 0, 1'b1);
      model.delete();
      for (int k = 0; k < 5; k++) begin
        out_ready = rdy_pat[k];
        in_valid  = 1'b1;
        in_data   = DW'(100);
        check("bp_data", int'(out_data), dat_pat[k]);
        check("bp_count", int'(count), cnt_pat[k]);
        check("bp_last", int'(out_last), (k == 4) ? 1 : 0);
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("bp_end_count", int'(count), 0);
      check("bp_end_busy", int'(busy), 0);
    end

    // clear during FILL with a concurrent sample
    push(6, 0, 1'b0);
    push(2, 0, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'(50);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    model.delete();
    check("clr_fill_count", int'(count), 0);
    check("clr_fill_busy", int'(busy), 0);
    push(7, 0, 1'b1);
    check("clr_fill_out_data", int'(out_data), 7);
    check("clr_fill_out_last", int'(out_last), 1);
    drain_model(1'b0, 1'b0);

    // clear mid-DRAIN
    push(1, 0, 1'b0);
    push(2, 0, 1'b0);
    push(3, 0, 1'b1);
    out_ready = 1'b1;
    check("clr_drain_first", int'(out_data), 3);
    step();
    clear = 1'b1;
    step();
    clear     = 1'b0;
    out_ready = 1'b0;
    model.delete();
    check("clr_drain_count", int'(count), 0);
    check("clr_drain_busy", int'(busy), 0);
    check("clr_drain_valid", int'(out_valid), 0);
    check("clr_drain_in_ready", int'(in_ready), 1);

    // reset mid-DRAIN
    push(9, 0, 1'b0);
    push(8, 0, 1'b1);
    out_ready = 1'b1;
    reset     = 1'b1;
    #1;
    check("rst_drain_in_ready_low", int'(in_ready), 0);
    step();
    check("rst_drain_valid", int'(out_valid), 0);
    check("rst_drain_count", int'(count), 0);
    reset     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_drain_in_ready", int'(in_ready), 1);
    model.delete();

    // Random bursts against the reference queue
    for (int b = 0; b < 40; b++) begin
      int len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        int v = (b % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
        push(v, $urandom_range(0, 255), k == len - 1);
      end
      drain_model(1'b1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
